// File: rtl/ship_pkg.sv
// ship_pkg: shared constants for the ship sprite pipeline (motion stage and
// renderer). Holds the active-video geometry, sprite size and the 2-bit
// motion-direction encoding reported on the dir port of ship_motion.
// No ports; import with "import ship_pkg::*;".
package ship_pkg;

    localparam int AV_X   = 640;
    localparam int AV_Y   = 480;
    localparam int SHIP_W = 64;
    localparam int SHIP_H = 64;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    // Direction code for a signed per-frame step total.
    function automatic logic [1:0] dir_of(input logic signed [6:0] acc);
        if (acc > 7'sd0)      return DIR_RIGHT;
        else if (acc < 7'sd0) return DIR_LEFT;
        else                  return DIR_NONE;
    endfunction

endpackage

// File: rtl/ship_motion_quad_decoder.sv
// quad_decoder: quadrature front end for the ship motion stage.
// Double-flop synchronizes the raw encoder channels, primes the previous-state
// register on the first clock after reset release, then decodes each
// transition of the synchronized pair {a,b} into a single quarter-step.
//   clk, reset (async, active-low)
//   rota, rotb  : raw encoder channels, asynchronous to clk
//   step_valid  : one valid quarter-step decoded this cycle
//   step_dir    : 1 = clockwise (+1, right), 0 = counter-clockwise (-1, left)
// Clockwise order is 00 -> 01 -> 11 -> 10 -> 00. A change of both bits at once
// is ambiguous and is dropped, but the previous state still follows it.
module quad_decoder (
    input  logic clk,
    input  logic reset,
    input  logic rota,
    input  logic rotb,
    output logic step_valid,
    output logic step_dir
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_ab_q, prev_ab_d;
    logic       primed_q, primed_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            prev_ab_q <= 2'b00;
            primed_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_ab_q <= prev_ab_d;
            primed_q  <= primed_d;
        end
    end

    always_comb begin
        sync1_d    = {rota, rotb};
        sync2_d    = sync1_q;
        prev_ab_d  = sync2_q;
        primed_d   = 1'b1;
        step_valid = 1'b0;
        step_dir   = 1'b0;
        // Before priming, only capture the current state; no count.
        if (primed_q) begin
            case ({prev_ab_q, sync2_q})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                    step_valid = 1'b1;
                    step_dir   = 1'b1;
                end
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                    step_valid = 1'b1;
                    step_dir   = 1'b0;
                end
                default: begin
                    step_valid = 1'b0;
                    step_dir   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ship_motion.sv
// ship_motion: converts rotary-encoder quadrature into the ship sprite
// position. Quarter-steps accumulate in a saturating signed counter during the
// frame and are applied once per frame_tick, so the sprite never moves
// mid-scan.
//   clk         : pixel clock
//   reset       : asynchronous active-low reset
//   rota, rotb  : raw encoder channels (asynchronous)
//   frame_tick  : one-cycle pulse at start of vblank
//   ship_x      : ship left edge, updated the cycle after frame_tick
//   ship_y      : constant ship top row
//   pos_valid   : one-cycle pulse when ship_x has been recommitted
//   dir         : last committed motion (ship_pkg DIR_* codes)
// Build option SHIP_WRAP_EN: when defined, the committed position wraps
// around the legal span instead of clamping at its edges.
module ship_motion
    import ship_pkg::*;
#(
    parameter int X_INIT  = (AV_X - SHIP_W) / 2,
    parameter int Y_POS   = 400,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = AV_X - SHIP_W,
    parameter int STEP_PX = 2,
    parameter int ACC_MAX = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rota,
    input  logic       rotb,
    input  logic       frame_tick,
    output logic [9:0] ship_x,
    output logic [9:0] ship_y,
    output logic       pos_valid,
    output logic [1:0] dir
);

    localparam logic signed [6:0]  ACC_POS = 7'(ACC_MAX);
    localparam logic signed [6:0]  ACC_NEG = 7'(-ACC_MAX);
    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] STEP_S  = 12'(STEP_PX);
`ifdef SHIP_WRAP_EN
    localparam logic signed [11:0] SPAN_S  = 12'(X_MAX - X_MIN + 1);
`endif

    logic step_valid;
    logic step_dir;

    quad_decoder u_quad_decoder (
        .clk        (clk),
        .reset      (reset),
        .rota       (rota),
        .rotb       (rotb),
        .step_valid (step_valid),
        .step_dir   (step_dir)
    );

    logic signed [6:0]  acc_q, acc_d;
    logic [9:0]         ship_x_q, ship_x_d;
    logic               pos_valid_q, pos_valid_d;
    logic [1:0]         dir_q, dir_d;

    logic signed [6:0]  acc_stepped;
    logic signed [6:0]  acc_fresh;
    logic signed [11:0] acc_ext;
    logic signed [11:0] next_raw;
    logic signed [11:0] next_fit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= 7'sd0;
            ship_x_q    <= 10'(X_INIT);
            pos_valid_q <= 1'b0;
            dir_q       <= DIR_NONE;
        end else begin
            acc_q       <= acc_d;
            ship_x_q    <= ship_x_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        // Saturating accumulate: a step into the limit is simply dropped.
        acc_stepped = acc_q;
        acc_fresh   = 7'sd0;
        if (step_valid) begin
            if (step_dir) begin
                acc_fresh = 7'sd1;
                if (acc_q != ACC_POS) acc_stepped = acc_q + 7'sd1;
            end else begin
                acc_fresh = -7'sd1;
                if (acc_q != ACC_NEG) acc_stepped = acc_q - 7'sd1;
            end
        end

        acc_ext  = {{5{acc_q[6]}}, acc_q};
        next_raw = $signed({2'b00, ship_x_q}) + acc_ext * STEP_S;

`ifdef SHIP_WRAP_EN
        // |acc*STEP_PX| is far below the span, so one correction suffices.
        if (next_raw < X_MIN_S)      next_fit = next_raw + SPAN_S;
        else if (next_raw > X_MAX_S) next_fit = next_raw - SPAN_S;
        else                         next_fit = next_raw;
`else
        if (next_raw < X_MIN_S)      next_fit = X_MIN_S;
        else if (next_raw > X_MAX_S) next_fit = X_MAX_S;
        else                         next_fit = next_raw;
`endif

        ship_x_d    = ship_x_q;
        pos_valid_d = 1'b0;
        dir_d       = dir_q;
        acc_d       = acc_stepped;
        if (frame_tick) begin
            // Commit uses the pre-step total; a coincident step seeds the
            // next frame so it is not lost.
            ship_x_d    = next_fit[9:0];
            pos_valid_d = 1'b1;
            dir_d       = dir_of(acc_q);
            acc_d       = acc_fresh;
        end
    end

    assign ship_x    = ship_x_q;
    assign ship_y    = 10'(Y_POS);
    assign pos_valid = pos_valid_q;
    assign dir       = dir_q;

endmodule

// File: doc/ship_motion.md
Name: ship_motion

Overview:
Upstream stage of the ship sprite renderer: converts raw rotary-encoder quadrature inputs (rota/rotb) into the ship_x/ship_y position the renderer consumes. Quarter-steps accumulate during the frame and are applied once per frame_tick (vblank), so the sprite never moves mid-scan. Position is clamped to the active-video region so the 64x64 sprite stays fully visible.

Parameters:
X_INIT, 288, ship_x after reset; centred, (640-64)/2
Y_POS, 400, constant ship_y row
X_MIN, 0, leftmost legal ship_x
X_MAX, 576, rightmost legal ship_x (AV_X - SHIP_W)
STEP_PX, 2, pixels moved per quadrature quarter-step
ACC_MAX, 31, magnitude limit of the signed per-frame step accumulator

Ports:
clk  in  1  system clock (pixel-clock domain)
reset  in  1  asynchronous, active-low reset (0 = reset)
rota  in  1  raw encoder channel A, asynchronous to clk
rotb  in  1  raw encoder channel B, asynchronous to clk
frame_tick  in  1  one-cycle pulse at start of vblank
ship_x  out  10  ship left edge, pixels
ship_y  out  10  ship top edge, pixels
pos_valid  out  1  one-cycle pulse when ship_x has been recommitted
dir  out  2  last committed motion: 00 none, 01 right, 10 left

Behaviour:
- Reset (reset=0, async assert, sync release): ship_x=X_INIT, ship_y=Y_POS, pos_valid=0, dir=00, accumulator=0, sync flops=0, primed=0.
- Sync: rota/rotb each pass through a 2-flop synchronizer; decoder samples stage 2. rota/rotb edge affects the accumulator 3 clk later.
- Prime: first clock after reset release, decoder loads prev_ab from the synced value with no count, then sets primed=1. Prevents a spurious step when the encoder rests at 11.
- Decode, prev_ab -> cur_ab: 00->01->11->10->00 = +1 (CW, right); reverse = -1; no change = 0; both bits changed (00<->11, 01<->10) = invalid, ignored, prev_ab still updated.
- Accumulator: signed 7-bit; +/-1 per valid step; saturates at +/-ACC_MAX; further steps in the same direction dropped.
- Commit on frame_tick:
  - next = ship_x + acc*STEP_PX, computed in 12-bit signed; clamp to [X_MIN, X_MAX]; registered into ship_x the cycle after frame_tick.
  - pos_valid=1 in that same cycle.
  - dir = 01 if acc>0, 10 if acc<0, 00 if acc==0 (pos_valid still pulses; ship_x unchanged).
  - Accumulator cleared to 0.
- Simultaneous step and frame_tick: the committed value excludes that step; accumulator becomes +/-1 (not 0), so no step is lost.
- Back-to-back frame_tick: each commits independently; second commits only steps arriving in between.
- ship_y is constant Y_POS, never changes.
- Reset mid-frame: pending accumulator discarded; position returns to X_INIT; re-prime required.

Optional Feature:
SHIP_WRAP_EN
- Defined: no clamp; next is taken modulo the span (X_MAX-X_MIN+1) and re-based at X_MIN, so the ship exits one edge and reappears at the other. Example: X_MIN=0, ship_x=574, +3 steps at STEP_PX=2 -> ship_x=3.
- Undefined: saturating clamp as above. Ports and latency identical in both builds.

Decomposition:
- Shared package ship_pkg: AV_X=640, AV_Y=480, SHIP_W=64, SHIP_H=64, 2-bit dir encoding constants. The renderer and this block both import it.
- Sub-module quad_decoder: synchronizer, prime logic and transition decode. Outputs step_valid and step_dir. Top holds accumulator, commit and clamp logic.

Test Plan:
- Reset: hold reset=0 with rota=rotb=1, release -> ship_x=288, ship_y=400, dir=00, no pos_valid; first frame_tick -> ship_x stays 288, pos_valid pulses once.
- 4 CW quarter-steps (00,01,11,10,00), then frame_tick -> ship_x=296 one cycle later, dir=01, pos_valid=1 for exactly 1 cycle.
- Start at 288, 40 CCW steps in one frame -> accumulator saturates at -31; commit gives 288-62=226; then 120 more CCW steps over several frames -> ship_x clamps at 0, never underflows.
- Invalid jumps 00->11 and 01->10 -> accumulator unchanged; next frame_tick leaves ship_x unchanged, dir=00.
- Step landing on the same clk as frame_tick -> that commit excludes it; the following frame_tick adds +/-2.
- Assert reset with accumulator at +10 mid-frame -> ship_x=288 immediately; after release with no steps, frame_tick leaves 288. With SHIP_WRAP_EN: 574 plus 3 CW steps -> 3.
